// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//
// Raster timing for the text-mode VGA display. Produces the pixel-rate
// strobe, the horizontal/vertical position counters consumed by the
// character-address stage, and active-low sync plus blanking. Sync and
// bright are delayed by PIPE_DELAY pixel periods so they stay aligned
// with pixel data leaving the character-RAM/glyph-ROM pipeline.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   pix_en         one-clk pixel strobe (every CLK_DIV clocks)
//   pixel_counter  horizontal position, 0..H_TOTAL-1
//   line_counter   vertical position, 0..V_TOTAL-1
//   hsync          active-low horizontal sync, delayed
//   vsync          active-low vertical sync, delayed
//   bright         high in the visible region, delayed
//   frame_start    one-clk pulse on the frame wrap, undelayed

module vga_timing_gen #(
    parameter int CLK_DIV    = 2,
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_en,
    output logic [9:0] pixel_counter,
    output logic [9:0] line_counter,
    output logic       hsync,
    output logic       vsync,
    output logic       bright,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode bounds are 11 bits wide so an end bound of 1024 still fits.
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);

    logic [DIV_W-1:0] div;
    logic [10:0]      pc_x;
    logic [10:0]      lc_x;
    logic             hs_raw;
    logic             vs_raw;
    logic             bright_raw;

    // Pixel-rate divider. With CLK_DIV=1 div is stuck at 0, so pix_en
    // is permanently high, including while reset is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign pix_en = (div == DIV_LAST);

    // Position counters, advancing once per pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_counter <= '0;
            line_counter  <= '0;
        end else if (pix_en) begin
            if (pixel_counter == H_LAST) begin
                pixel_counter <= '0;
                if (line_counter == V_LAST) begin
                    line_counter <= '0;
                end else begin
                    line_counter <= line_counter + 10'd1;
                end
            end else begin
                pixel_counter <= pixel_counter + 10'd1;
            end
        end
    end

    // Raw decode from the counter registers.
    assign pc_x       = {1'b0, pixel_counter};
    assign lc_x       = {1'b0, line_counter};
    assign hs_raw     = !((pc_x >= HS_START) && (pc_x < HS_END));
    assign vs_raw     = !((lc_x >= VS_START) && (lc_x < VS_END));
    assign bright_raw = (pc_x < H_VIS) && (lc_x < V_VIS);

    assign frame_start = pix_en && (pixel_counter == H_LAST) && (line_counter == V_LAST);

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hsync  = hs_raw;
            assign vsync  = vs_raw;
            assign bright = bright_raw;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] hs_dly_p;
            logic [PIPE_DELAY-1:0] vs_dly_p;
            logic [PIPE_DELAY-1:0] br_dly_p;
            logic [PIPE_DELAY:0]   hs_shift;
            logic [PIPE_DELAY:0]   vs_shift;
            logic [PIPE_DELAY:0]   br_shift;

            // Bit 0 of each shift vector is the raw decode; the register
            // takes the low PIPE_DELAY bits, so the oldest stage sits at
            // the top and is the output.
            assign hs_shift = {hs_dly_p, hs_raw};
            assign vs_shift = {vs_dly_p, vs_raw};
            assign br_shift = {br_dly_p, bright_raw};

            // Delay stages: one shift per pixel period.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hs_dly_p <= '1;
                    vs_dly_p <= '1;
                    br_dly_p <= '0;
                end else if (pix_en) begin
                    hs_dly_p <= hs_shift[PIPE_DELAY-1:0];
                    vs_dly_p <= vs_shift[PIPE_DELAY-1:0];
                    br_dly_p <= br_shift[PIPE_DELAY-1:0];
                end
            end

            assign hsync  = hs_dly_p[PIPE_DELAY-1];
            assign vsync  = vs_dly_p[PIPE_DELAY-1];
            assign bright = br_dly_p[PIPE_DELAY-1];
        end
    endgenerate

endmodule
